// File: rtl/ifetch_pkg.sv
// Shared width and types for the instruction prefetch queue.
// No logic; imported by the interface, the FIFO and the top level.
package ifetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Memory-side req/ack bus, decode-side valid/ready bus and redirect, as one bundle.
// master = prefetch queue, slave = memory/decode/branch unit (or a bench standing in for them).
interface ifetch_queue_if;
  import ifetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_ack, imem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_ack, imem_rdata, out_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with single-cycle flush; push and pop may coincide even when full.
// Head is visible the cycle after the push edge; dout reads 0 while empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: one outstanding word fetch, DEPTH buffered {pc, instr}.
// Ack on edge N is visible at out_* in cycle N+1; fetch stalls when no slot remains.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic            clock,
  input logic            reset,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push, pop, space, not_empty;
  fq_entry_t       head;
  fq_entry_t       wr_entry;

  assign not_empty  = (count != '0);
  assign push       = (state_q == WAIT) && bus.imem_ack && !bus.redirect;
  assign pop        = not_empty && bus.out_ready && !bus.redirect;
  assign count_next = count + CW'(push) - CW'(pop);
  // An outstanding request already owns a slot, so issue only if one is free after this cycle.
  assign space      = (count_next < CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (!bus.redirect && space) state_d = WAIT;
      end
      WAIT: begin
        if (bus.redirect)      state_d = bus.imem_ack ? IDLE : WAIT_DROP;
        else if (bus.imem_ack) state_d = space ? WAIT : IDLE;
      end
      WAIT_DROP: begin
        if (bus.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.redirect)  fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (push)     fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign wr_entry = '{pc: fetch_pc_q, instr: bus.imem_rdata};

  ifq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2 * XLEN)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(bus.redirect),
    .din  (wr_entry),
    .dout (head),
    .count(count)
  );

  assign bus.imem_req  = (state_q != IDLE);
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = not_empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand sequences, and random traffic
// compared against a queue-based reference model.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mem_cnt = 0;

  always #5 clock = ~clock;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        red;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_req;
  bit          m_drop;
  vec_t        tbl[15];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.out_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    @(posedge clock); #1;
    check("rst_req",   32'(bus.imem_req),  32'h0);
    check("rst_addr",  bus.imem_addr,      32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_instr", bus.out_instr,      32'h0);
    check("rst_pc",    bus.out_pc,         32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    mq.delete();
    m_pc = 32'h0; m_req = 1'b0; m_drop = 1'b0; mem_cnt = 0;
  endtask

  // One cycle: drive inputs, compare outputs to the model, advance the model and the clock.
  task automatic cycle(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic red, input logic [31:0] rpc);
    bit acc, popm;
    bus.imem_ack = ack; bus.imem_rdata = rdata; bus.out_ready = rdy;
    bus.redirect = red; bus.redirect_pc = rpc;
    check("imem_req",  32'(bus.imem_req),  32'(m_req));
    check("imem_addr", bus.imem_addr,      m_pc);
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    check("out_pc",    bus.out_pc,         (mq.size() != 0) ? mq[0].pc : 32'h0);
    check("out_instr", bus.out_instr,      (mq.size() != 0) ? mq[0].instr : 32'h0);
    acc  = m_req && ack;
    popm = (mq.size() != 0) && rdy && !red;
    if (red) begin
      mq.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_drop = m_req && !acc;
      m_req  = m_drop;
    end else if (acc && m_drop) begin
      m_drop = 1'b0;
      m_req  = 1'b0;
    end else begin
      if (acc) begin
        mq.push_back('{pc: m_pc, instr: rdata});
        m_pc = m_pc + 32'd4;
      end
      if (popm) void'(mq.pop_front());
      if (!(m_req && !acc)) m_req = (mq.size() < DEPTH);
    end
    @(posedge clock); #1;
  endtask

  // Memory acking after `lat` extra cycles of request; junk acks optionally while idle.
  task automatic mem_cycle(input int lat, input logic rdy, input logic red,
                           input logic [31:0] rpc, input bit junk);
    logic ack;
    if (bus.imem_req) begin
      ack     = (mem_cnt >= lat);
      mem_cnt = ack ? 0 : mem_cnt + 1;
    end else begin
      ack     = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_cnt = 0;
    end
    cycle(ack, ack ? memf(bus.imem_addr) : $urandom(), rdy, red, rpc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, last, nval;
    logic [31:0] lat;
    //          ack  rdy  red  rpc           req  addr          vld  pc
    tbl[0]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0};
    tbl[1]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0};
    tbl[2]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0};
    tbl[3]  = '{1'b0,1'b1,1'b1,32'h203,      1'b1,32'h8,        1'b1,32'h4};
    tbl[4]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h200,      1'b0,32'h0};
    tbl[5]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,32'h200,      1'b0,32'h0};
    tbl[6]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h200,      1'b0,32'h0};
    tbl[7]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,32'h200,      1'b0,32'h0};
    tbl[8]  = '{1'b0,1'b1,1'b1,32'hFFFFFFFF, 1'b1,32'h204,      1'b1,32'h200};
    tbl[9]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,32'hFFFFFFFC, 1'b0,32'h0};
    tbl[10] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,32'h0};
    tbl[11] = '{1'b1,1'b1,1'b0,32'h0,        1'b1,32'hFFFFFFFC, 1'b0,32'h0};
    tbl[12] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'hFFFFFFFC};
    tbl[13] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'hFFFFFFFC};
    tbl[14] = '{1'b0,1'b1,1'b1,32'h40,       1'b1,32'h4,        1'b1,32'h0};

    // Directed table: start-up, redirect to 0x203, wrap past 0xFFFFFFFC.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.imem_ack    = tbl[i].ack;
      bus.imem_rdata  = memf(bus.imem_addr);
      bus.out_ready   = tbl[i].rdy;
      bus.redirect    = tbl[i].red;
      bus.redirect_pc = tbl[i].rpc;
      check("tbl_req",   32'(bus.imem_req),  32'(tbl[i].e_req));
      check("tbl_addr",  bus.imem_addr,      tbl[i].e_addr);
      check("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].e_vld));
      check("tbl_pc",    bus.out_pc,         tbl[i].e_pc);
      check("tbl_instr", bus.out_instr,      tbl[i].e_vld ? memf(tbl[i].e_pc) : 32'h0);
      @(posedge clock); #1;
    end

    // Fill with out_ready low, then drain in order with fetch resuming at 16.
    do_reset();
    for (int i = 0; i < 8; i++) mem_cycle(0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("full_req",   32'(bus.imem_req),  32'h0);
    check("full_valid", 32'(bus.out_valid), 32'h1);
    for (int i = 0; i < 6; i++) begin
      check("drain_pc",    bus.out_pc,    32'(4 * i));
      check("drain_instr", bus.out_instr, memf(32'(4 * i)));
      mem_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    end

    // Three-cycle memory latency: one entry every four cycles.
    do_reset();
    last = -1; nval = 0;
    for (int c = 0; c < 21; c++) begin
      if (bus.out_valid) begin
        if (last >= 0) check("lat3_gap", 32'(c - last), 32'd4);
        last = c; nval++;
      end
      mem_cycle(3, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    check("lat3_entries", 32'(nval), 32'd4);

    // Redirect to 0x100 while the request at 8 is outstanding.
    do_reset();
    k = 0;
    while (!(bus.imem_req && bus.imem_addr == 32'h8) && k < 50) begin
      mem_cycle(2, 1'b1, 1'b0, 32'h0, 1'b0); k++;
    end
    check("reach_req8", 32'(k < 50), 32'h1);
    mem_cycle(2, 1'b1, 1'b1, 32'h100, 1'b0);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      mem_cycle(2, 1'b1, 1'b0, 32'h0, 1'b0); k++;
    end
    check("redir_first_pc", bus.out_pc, 32'h100);

    // Redirect with out_ready high on a full queue (stray ack while idle is ignored).
    do_reset();
    for (int i = 0; i < 8; i++) mem_cycle(0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h80);
    check("flush_valid", 32'(bus.out_valid), 32'h0);
    check("flush_req",   32'(bus.imem_req),  32'h0);
    mem_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("refetch_req",  32'(bus.imem_req), 32'h1);
    check("refetch_addr", bus.imem_addr,     32'h80);

    // Redirect coincident with ack while the last free slot is reserved.
    do_reset();
    for (int i = 0; i < 8; i++) mem_cycle(0, 1'b0, 1'b0, 32'h0, 1'b0);
    mem_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, memf(bus.imem_addr), 1'b1, 1'b1, 32'h300);
    check("ackredir_valid", 32'(bus.out_valid), 32'h0);
    mem_cycle(0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("ackredir_addr", bus.imem_addr, 32'h300);

    // Random traffic against the model.
    do_reset();
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rdy, red;
      logic [31:0] rpc;
      if (i % 500 == 0) lat = $urandom_range(0, 2);
      rdy = ($urandom_range(0, 9) < 7);
      red = ($urandom_range(0, 31) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom();
      mem_cycle(int'(lat), rdy, red, rpc, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
